// File: rtl/compound_relay_rr.sv
// Round-robin relay: N_CH blocking input channels -> one tagged blocking output channel.
// Latency: 1 cycle from input read to b_out_notify; 2 cycles minimum per payload.
// Backpressure: holds b_out_data with all b_in_notify low until b_out_sync; optional parity via COMPOUND_RELAY_PAR_EN.
module compound_relay_rr #(
  parameter int DATA_W = 32,
  parameter int N_CH   = 4,
  parameter int CNT_W  = 16,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*DATA_W-1:0] b_in_data,
  input  logic [N_CH-1:0]        b_in_sync,
  output logic [N_CH-1:0]        b_in_notify,
  output logic [CH_W+DATA_W-1:0] b_out_data,
  input  logic                   b_out_sync,
  output logic                   b_out_notify,
  output logic                   phase,
  output logic [CNT_W-1:0]       xfer_count
`ifdef COMPOUND_RELAY_PAR_EN
  ,
  output logic                   b_out_par
`endif
);

  typedef enum logic {
    SECTION_A = 1'b0,
    SECTION_B = 1'b1
  } phase_t;

  typedef struct packed {
    logic [CH_W-1:0]   tag;
    logic [DATA_W-1:0] x;
  } out_t;

  phase_t            state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d, ptr_inc;
  logic [N_CH-1:0]   in_notify_q, in_notify_d;
  logic              out_notify_q, out_notify_d;
  out_t              out_q, out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sel_x;
  logic              sel_sync;

  // Next channel to examine; explicit wrap keeps ptr below N_CH for non-power-of-2 N_CH
  always_comb begin
    ptr_inc = (ptr_q == CH_W'(N_CH - 1)) ? '0 : ptr_q + 1'b1;
  end

  // Select payload and valid of the channel currently pointed at
  always_comb begin
    sel_x    = '0;
    sel_sync = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (ptr_q == CH_W'(i)) begin
        sel_x    = b_in_data[i*DATA_W +: DATA_W];
        sel_sync = b_in_sync[i];
      end
    end
  end

  // Next-state and registered-output values for the read/write phases
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    in_notify_d  = in_notify_q;
    out_notify_d = out_notify_q;
    out_d        = out_q;
    cnt_d        = cnt_q;
    case (state_q)
      SECTION_A: begin
        if (sel_sync) begin
          // Read the selected channel; ptr keeps the captured channel during the write phase
          state_d      = SECTION_B;
          out_d.tag    = ptr_q;
          out_d.x      = sel_x;
          in_notify_d  = '0;
          out_notify_d = 1'b1;
        end else begin
          ptr_d       = ptr_inc;
          in_notify_d = N_CH'(1) << ptr_inc;
        end
      end
      SECTION_B: begin
        if (b_out_sync) begin
          state_d      = SECTION_A;
          ptr_d        = ptr_inc;
          in_notify_d  = N_CH'(1) << ptr_inc;
          out_notify_d = 1'b0;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = SECTION_A;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight payload
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SECTION_A;
      ptr_q        <= '0;
      in_notify_q  <= N_CH'(1);
      out_notify_q <= 1'b0;
      out_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      in_notify_q  <= in_notify_d;
      out_notify_q <= out_notify_d;
      out_q        <= out_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef COMPOUND_RELAY_PAR_EN
  logic par_q;

  // Parity tracks whatever is loaded into b_out_data, tag included
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^out_d;
    end
  end

  assign b_out_par = par_q;
`endif

  assign b_in_notify  = in_notify_q;
  assign b_out_notify = out_notify_q;
  assign b_out_data   = out_q;
  assign phase        = state_q;
  assign xfer_count   = cnt_q;

endmodule

// File: doc/compound_relay_rr.md
Name: compound_relay_rr

Overview:
- Parametrised successor of the single-channel compound read/write relay.
- Takes compound payloads from N_CH blocking input channels, serviced round-robin, and forwards each to one blocking output channel tagged with its source channel.
- Two-phase control (SECTION_A = read, SECTION_B = write) with a saturating transfer counter.
- Sits between producer modules and a shared consumer in the generated top level.

Parameters:
- DATA_W, 32, width of the payload field x.
- N_CH, 4, number of input channels; legal range 2..16.
- CNT_W, 16, width of the transfer counter.
- Local: CH_W = $clog2(N_CH).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- b_in_data  input  N_CH*DATA_W  payload x per channel; channel i occupies bits [i*DATA_W +: DATA_W].
- b_in_sync  input  N_CH  producer i has valid data.
- b_in_notify  output  N_CH  relay is ready to read channel i; registered.
- b_out_data  output  CH_W+DATA_W  {source channel, x}; registered.
- b_out_sync  input  1  consumer accepts.
- b_out_notify  output  1  relay offers data; registered.
- phase  output  1  0 = SECTION_A, 1 = SECTION_B.
- xfer_count  output  CNT_W  completed output transfers.
- b_out_par  output  1  only with COMPOUND_RELAY_PAR_EN.

Behaviour:
- Transfer definition: a transfer on a channel happens in any cycle where that channel's notify and sync are both 1 at the rising edge.
- Reset (rst=1 at an edge), regardless of current phase:
  - phase=SECTION_A, ptr=0, b_in_notify=1 (one-hot on channel 0).
  - b_out_notify=0, b_out_data=0, xfer_count=0, b_out_par=0.
  - An in-flight payload is discarded.
- SECTION_A:
  - b_in_notify is exactly one-hot at ptr; b_out_notify=0.
  - If b_in_sync[ptr]=1: capture {ptr, x[ptr]} into b_out_data. Next cycle: phase=SECTION_B, b_in_notify=0, b_out_notify=1.
  - Else: ptr advances by 1 and b_in_notify moves with it. Wrap N_CH-1 -> 0, including non-power-of-2 N_CH; ptr never holds a value >= N_CH.
  - Sync on non-selected channels is ignored; those producers must hold.
- SECTION_B:
  - b_out_notify=1; b_out_data held stable; all b_in_notify=0.
  - If b_out_sync=1: transfer completes. Next cycle: phase=SECTION_A, ptr = captured channel + 1 (wrapped), b_in_notify one-hot at the new ptr, b_out_notify=0.
  - xfer_count increments on completion and saturates at 2^CNT_W-1.
  - b_out_data keeps its last value after the transfer.
- Latency:
  - Input transfer to b_out_notify=1: 1 cycle.
  - Minimum full round trip: 2 cycles per payload (one read cycle, one write cycle).
- Fairness: after serving channel k, the next channel examined is k+1. A continuously-valid set of channels is served in strict rotation.
- Simultaneous events:
  - All sync inputs high: only ptr is read.
  - b_out_sync high during SECTION_A has no effect.
  - b_in_sync toggling during SECTION_B has no effect.
- Payload is passed unmodified; there is no arithmetic on x.

Optional Feature:
- Macro COMPOUND_RELAY_PAR_EN.
- Defined:
  - Port b_out_par exists and is registered with b_out_data; value is even parity (XOR-reduce) over the full b_out_data including the tag.
  - Reset value 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then hold all sync=0 for 6 cycles (N_CH=4) -> b_in_notify sequence 0001, 0010, 0100, 1000, 0001, 0010; b_out_notify=0; phase=0.
- Ch2 sync=1 with x=0xDEADBEEF, b_out_sync=1 -> b_out_data={2'd2, 0xDEADBEEF} with b_out_notify=1 one cycle after the read; next cycle b_in_notify=1000; xfer_count=1.
- All four channels sync=1, b_out_sync=1, x_i=i -> outputs in order tags 0,1,2,3,0; one payload every 2 cycles.
- b_out_sync=0 for 10 cycles in SECTION_B -> b_out_data and b_out_notify stable; b_in_notify=0; producer sync ignored; completes on the first b_out_sync=1.
- CNT_W=3, run 9 transfers -> xfer_count saturates at 7.
- rst asserted mid-SECTION_B -> next cycle phase=0, b_out_notify=0, b_in_notify=0001, xfer_count=0; with PAR_EN, payload {1, 0x3} -> b_out_par=1.
